// File: rtl/alu_stage.sv
// 8-bit ALU stage: single-cycle arith/logic, bit-serial shifts and rotates.
// Define ALU_MUL_EN to turn opcode 15 into an 8-cycle shift-add MUL.
module alu_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    input  logic             i_start,
    input  logic             i_writeFlags,
    input  logic             i_nBusEn,
    output logic [WIDTH-1:0] o_bus,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state_q, state_d;
    logic [7:0] work_q, work_d;
    logic [7:0] result_q, result_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic [3:0] flags_q, flags_d;
    logic       wf_q, wf_d;
    logic       done_q, done_d;

`ifdef ALU_MUL_EN
    logic [15:0] acc_q, acc_d, mcand_q, mcand_d, acc_nx;
    logic [7:0]  mplier_q, mplier_d;
`endif

    logic [7:0] bb, res, sh_val;
    logic [8:0] sum;
    logic       ci, c, v, sh_c, is_shift;

    // Flags are {Z,N,C,V}; C lives at bit 1.
    always_comb begin
        bb = i_b;
        ci = 1'b0;
        unique case (i_op)
            4'd1:    ci = flags_q[1];
            4'd2:    begin bb = ~i_b; ci = 1'b1; end
            4'd3:    begin bb = ~i_b; ci = flags_q[1]; end
            4'd13:   bb = 8'h01;
            4'd14:   begin bb = 8'hFE; ci = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, i_a} + {1'b0, bb} + {8'd0, ci};
        res = sum[7:0];
        c   = sum[8];
        v   = (i_a[7] == bb[7]) && (sum[7] != i_a[7]);
        unique case (i_op)
            4'd4:    begin res = i_a & i_b; c = 1'b0; v = 1'b0; end
            4'd5:    begin res = i_a | i_b; c = 1'b0; v = 1'b0; end
            4'd6:    begin res = i_a ^ i_b; c = 1'b0; v = 1'b0; end
            4'd7:    begin res = ~i_a;      c = 1'b0; v = 1'b0; end
            4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                     begin res = i_a; c = flags_q[1]; v = 1'b0; end
            4'd15:   begin res = i_b;       c = 1'b0; v = 1'b0; end
            default: ;
        endcase
    end

    assign is_shift = (i_op >= 4'd8) && (i_op <= 4'd12);

    always_comb begin
        sh_val = work_q;
        sh_c   = 1'b0;
        unique case (op_q)
            4'd8:    {sh_c, sh_val} = {work_q, 1'b0};
            4'd9:    {sh_val, sh_c} = {1'b0, work_q};
            4'd10:   {sh_val, sh_c} = {work_q[7], work_q};
            4'd11:   begin sh_val = {work_q[6:0], work_q[7]}; sh_c = work_q[7]; end
            4'd12:   begin sh_val = {work_q[0], work_q[7:1]}; sh_c = work_q[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        wf_d     = wf_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_nx   = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
`endif
        unique case (state_q)
            IDLE: if (i_start) begin
                op_d = i_op;
                wf_d = i_writeFlags;
                if (is_shift && i_b[2:0] != 3'd0) begin
                    state_d = SHIFT;
                    work_d  = i_a;
                    cnt_d   = {1'b0, i_b[2:0]};
                end
`ifdef ALU_MUL_EN
                else if (i_op == 4'd15) begin
                    state_d  = SHIFT;
                    cnt_d    = 4'd8;
                    acc_d    = '0;
                    mcand_d  = {8'd0, i_a};
                    mplier_d = i_b;
                end
`endif
                else begin
                    result_d = res;
                    done_d   = 1'b1;
                    if (i_writeFlags)
                        flags_d = {res == 8'd0, res[7], c, v};
                end
            end
            SHIFT: begin
                cnt_d = cnt_q - 4'd1;
`ifdef ALU_MUL_EN
                if (op_q == 4'd15) begin
                    acc_d    = acc_nx;
                    mcand_d  = {mcand_q[14:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[7:1]};
                    if (cnt_q == 4'd1) begin
                        state_d  = IDLE;
                        result_d = acc_nx[7:0];
                        done_d   = 1'b1;
                        if (wf_q)
                            flags_d = {acc_nx[7:0] == 8'd0, acc_nx[7],
                                       |acc_nx[15:8], 1'b0};
                    end
                end else
`endif
                begin
                    work_d = sh_val;
                    if (cnt_q == 4'd1) begin
                        state_d  = IDLE;
                        result_d = sh_val;
                        done_d   = 1'b1;
                        if (wf_q)
                            flags_d = {sh_val == 8'd0, sh_val[7], sh_c, 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            wf_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            wf_q     <= wf_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign o_result = result_q;
    assign o_flags  = flags_q;
    assign o_busy   = (state_q == SHIFT);
    assign o_done   = done_q;
    assign o_bus    = i_nBusEn ? {WIDTH{1'bz}} : result_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed-vector bench for alu_stage: arithmetic, logic, shifts, flags,
// back-to-back starts, reset abort and bus enable.
module tb_alu_stage;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_a, i_b;
    logic [3:0] i_op;
    logic       i_start, i_writeFlags, i_nBusEn;
    wire  [7:0] o_bus;
    logic [7:0] o_result;
    logic [3:0] o_flags;
    logic       o_busy, o_done;

    int n_vec = 0;
    int n_err = 0;

    alu_stage #(.WIDTH(8)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_a(i_a),
        .i_b(i_b),
        .i_op(i_op),
        .i_start(i_start),
        .i_writeFlags(i_writeFlags),
        .i_nBusEn(i_nBusEn),
        .o_bus(o_bus),
        .o_result(o_result),
        .o_flags(o_flags),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
    } vec_t;

    // Run with flags written; carry chains from one row to the next.
    vec_t vt [13] = '{
        '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101, 1},
        '{4'd2,  8'h10, 8'h20, 8'hF0, 4'b0100, 1},
        '{4'd3,  8'h05, 8'h01, 8'h03, 4'b0010, 1},
        '{4'd1,  8'h01, 8'h01, 8'h03, 4'b0000, 1},
        '{4'd4,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1},
        '{4'd5,  8'h00, 8'h00, 8'h00, 4'b1000, 1},
        '{4'd6,  8'hFF, 8'h0F, 8'hF0, 4'b0100, 1},
        '{4'd7,  8'h55, 8'h00, 8'hAA, 4'b0100, 1},
        '{4'd13, 8'hFF, 8'h00, 8'h00, 4'b1010, 1},
        '{4'd14, 8'h00, 8'h00, 8'hFF, 4'b0100, 1},
        '{4'd10, 8'h80, 8'h02, 8'hE0, 4'b0100, 3},
        '{4'd11, 8'h81, 8'h01, 8'h03, 4'b0010, 2},
        '{4'd9,  8'h03, 8'h02, 8'h00, 4'b1010, 3}
    };

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Start one op and wait (bounded) for o_done; poke>0 fires a stray
    // ADD start on that cycle of the wait.
    task automatic run(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic wf, input int poke,
                       output int lat, output int bc);
        i_op = op;
        i_a = a;
        i_b = b;
        i_writeFlags = wf;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        lat = 1;
        bc = 0;
        while (!o_done && lat < 20) begin
            if (o_busy) bc++;
            if (lat == poke) begin
                i_op = 4'd0;
                i_a = 8'h01;
                i_b = 8'h01;
                i_writeFlags = 1'b1;
                i_start = 1'b1;
            end
            tick();
            i_start = 1'b0;
            lat++;
        end
        check("done", {7'd0, o_done}, 8'h01);
    endtask

    initial begin
        int lat, bc, seen;
        i_reset = 1'b1;
        i_a = '0;
        i_b = '0;
        i_op = '0;
        i_start = 1'b0;
        i_writeFlags = 1'b0;
        i_nBusEn = 1'b0;
        tick();
        tick();
        check("rst_result", o_result, 8'h00);
        check("rst_flags", {4'd0, o_flags}, 8'h00);
        check("rst_busy", {7'd0, o_busy}, 8'h00);
        check("rst_done", {7'd0, o_done}, 8'h00);
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            run(vt[i].op, vt[i].a, vt[i].b, 1'b1, 0, lat, bc);
            check($sformatf("res%0d", i), o_result, vt[i].r);
            check($sformatf("flg%0d", i), {4'd0, o_flags}, {4'd0, vt[i].f});
            check($sformatf("lat%0d", i), 8'(lat), 8'(vt[i].lat));
        end

        run(4'd0, 8'h01, 8'h01, 1'b0, 0, lat, bc);
        check("nowf_res", o_result, 8'h02);
        check("nowf_flg", {4'd0, o_flags}, 8'h0A);
        tick();
        check("done_low", {7'd0, o_done}, 8'h00);

        run(4'd8, 8'h81, 8'h03, 1'b1, 2, lat, bc);
        check("shl_busy", 8'(bc), 8'd3);
        check("shl_lat", 8'(lat), 8'd4);
        check("shl_res", o_result, 8'h08);
        check("shl_flg", {4'd0, o_flags}, 8'h00);
        tick();
        check("shl_done1", {7'd0, o_done}, 8'h00);
        check("shl_hold", o_result, 8'h08);

        run(4'd0, 8'hFF, 8'h01, 1'b1, 0, lat, bc);
        check("cset_flg", {4'd0, o_flags}, 8'h0A);
        run(4'd12, 8'h01, 8'h00, 1'b1, 0, lat, bc);
        check("ror0_lat", 8'(lat), 8'd1);
        check("ror0_res", o_result, 8'h01);
        check("ror0_flg", {4'd0, o_flags}, 8'h02);
        run(4'd9, 8'h04, 8'h02, 1'b1, 0, lat, bc);
        check("b2b_lat", 8'(lat), 8'd3);
        check("b2b_res", o_result, 8'h01);
        check("b2b_flg", {4'd0, o_flags}, 8'h00);

        run(4'd7, 8'h5A, 8'h00, 1'b0, 0, lat, bc);
        i_nBusEn = 1'b1;
        #1;
        check("bus_off", {7'd0, o_bus === 8'hA5}, 8'h00);
        i_nBusEn = 1'b0;
        #1;
        check("bus_on", o_bus, 8'hA5);

`ifdef ALU_MUL_EN
        run(4'd15, 8'h10, 8'h10, 1'b1, 0, lat, bc);
        check("mul_busy", 8'(bc), 8'd8);
        check("mul_lat", 8'(lat), 8'd9);
        check("mul_res", o_result, 8'h00);
        check("mul_flg", {4'd0, o_flags}, 8'h0A);
        run(4'd15, 8'h0D, 8'h0B, 1'b1, 0, lat, bc);
        check("mul2_res", o_result, 8'h8F);
        check("mul2_flg", {4'd0, o_flags}, 8'h04);
`else
        run(4'd15, 8'h00, 8'h80, 1'b1, 0, lat, bc);
        check("pass_lat", 8'(lat), 8'd1);
        check("pass_res", o_result, 8'h80);
        check("pass_flg", {4'd0, o_flags}, 8'h04);
`endif

        i_op = 4'd8;
        i_a = 8'hFF;
        i_b = 8'h07;
        i_writeFlags = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("abort_busy", {7'd0, o_busy}, 8'h00);
        check("abort_res", o_result, 8'h00);
        check("abort_flg", {4'd0, o_flags}, 8'h00);
        seen = 0;
        repeat (12) begin
            if (o_done) seen++;
            tick();
        end
        check("abort_nodone", 8'(seen), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
